// File: rtl/signal_pattern_decoder_if.sv
// Lamp-pattern decoder bus: sample strobe and lamp word in, decoded mode and
// status out. The decoder sits on the slave side; the stimulus source is the master.
interface signal_pattern_decoder_if #(
    parameter int unsigned CW = 4
);
    logic          tick;
    logic [9:0]    LEDR;
    logic [1:0]    mode;
    logic          mode_valid;
    logic          seq_error;
    logic [CW-1:0] cycles;

    // Stimulus source: drives samples, observes the decode result.
    modport master (
        output tick,
        output LEDR,
        input  mode,
        input  mode_valid,
        input  seq_error,
        input  cycles
    );

    // Decoder: consumes samples, produces the registered decode result.
    modport slave (
        input  tick,
        input  LEDR,
        output mode,
        output mode_valid,
        output seq_error,
        output cycles
    );
endinterface

// File: rtl/signal_pattern_decoder.sv
// Turn-signal / hazard lamp pattern decoder.
// Watches the left (LEDR[9:7]) and right (LEDR[2:0]) lamp groups on each tick,
// locks onto a left, right or hazard blink sequence, counts completed blink
// cycles and flags samples that break the sequence.
module signal_pattern_decoder #(
    parameter int unsigned CW = 4
) (
    input logic                      clock,
    input logic                      reset,
    signal_pattern_decoder_if.slave  bus
);

    // State encoding doubles as the mode output code.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLeft   = 2'b01,
        StRight  = 2'b10,
        StHazard = 2'b11
    } state_e;

    localparam logic [CW-1:0] CyclesMax = {CW{1'b1}};
    localparam logic [CW-1:0] CyclesOne = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    MatchMax  = 2'd3;

    // Left group fills outward from bit 9, right group outward from bit 0.
    function automatic logic [2:0] left_pat(input logic [1:0] phase);
        logic [2:0] pat;
        unique case (phase)
            2'd0: pat = 3'b000;
            2'd1: pat = 3'b100;
            2'd2: pat = 3'b110;
            2'd3: pat = 3'b111;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    function automatic logic [2:0] right_pat(input logic [1:0] phase);
        logic [2:0] pat;
        unique case (phase)
            2'd0: pat = 3'b000;
            2'd1: pat = 3'b001;
            2'd2: pat = 3'b011;
            2'd3: pat = 3'b111;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    logic [2:0] l_grp;
    logic [2:0] r_grp;
    logic       unused_ledr;

    assign l_grp       = bus.LEDR[9:7];
    assign r_grp       = bus.LEDR[2:0];
    assign unused_ledr = ^bus.LEDR[6:3];

    state_e        state_q, state_d;
    logic [1:0]    p_q, p_d;
    logic [1:0]    m_q, m_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          seq_error_q, seq_error_d;
    logic          mode_valid_q, mode_valid_d;
    logic [1:0]    mode_q;

    logic [2:0]    exp_l;
    logic [2:0]    exp_r;
    logic          is_dark;
    logic          is_match;

    // Pattern expected on the next tick for the sequence currently tracked.
    // Hazard uses p[0]: 1 = lamps on (expect dark next), 0 = dark (expect on next).
    always_comb begin
        exp_l = 3'b000;
        exp_r = 3'b000;
        unique case (state_q)
            StLeft:   exp_l = left_pat(p_q + 2'd1);
            StRight:  exp_r = right_pat(p_q + 2'd1);
            StHazard: begin
                if (!p_q[0]) begin
                    exp_l = 3'b111;
                    exp_r = 3'b111;
                end
            end
            default: begin
                exp_l = 3'b000;
                exp_r = 3'b000;
            end
        endcase
    end

    // Classify the current sample against the expected pattern.
    always_comb begin
        is_dark  = (l_grp == 3'b000) && (r_grp == 3'b000);
        is_match = (l_grp == exp_l) && (r_grp == exp_r);
    end

    // Next-state decode; everything holds on non-tick edges except the error pulse.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        m_d         = m_q;
        cycles_d    = cycles_q;
        seq_error_d = 1'b0;

        if (bus.tick) begin
            if (state_q == StIdle) begin
                if (l_grp == 3'b000 && r_grp == 3'b001) begin
                    state_d = StRight;
                    p_d     = 2'd1;
                    m_d     = 2'd0;
                end else if (l_grp == 3'b100 && r_grp == 3'b000) begin
                    state_d = StLeft;
                    p_d     = 2'd1;
                    m_d     = 2'd0;
                end else if (l_grp == 3'b111 && r_grp == 3'b111) begin
                    state_d = StHazard;
                    p_d     = 2'd1;
                    m_d     = 2'd0;
                end else if (!is_dark) begin
                    seq_error_d = 1'b1;
                end
                cycles_d = '0;
            end else if (is_match) begin
                if (state_q == StHazard) begin
                    p_d = {1'b0, ~p_q[0]};
                end else begin
                    p_d = p_q + 2'd1;
                end
                if (m_q != MatchMax) begin
                    m_d = m_q + 2'd1;
                end
                // A matched all-dark sample closes one blink cycle.
                if (is_dark && cycles_q != CyclesMax) begin
                    cycles_d = cycles_q + CyclesOne;
                end
            end else begin
                // Unexpected dark is a cancel; anything else is a broken sequence.
                // Either way the sample is consumed here, not re-decoded as an entry.
                state_d     = StIdle;
                p_d         = 2'd0;
                m_d         = 2'd0;
                cycles_d    = '0;
                seq_error_d = !is_dark;
            end
        end

        mode_valid_d = (state_d != StIdle) && (m_d >= 2'd2);
    end

    // State and registered outputs; synchronous reset wins over a tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            p_q          <= 2'd0;
            m_q          <= 2'd0;
            cycles_q     <= '0;
            seq_error_q  <= 1'b0;
            mode_valid_q <= 1'b0;
            mode_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            m_q          <= m_d;
            cycles_q     <= cycles_d;
            seq_error_q  <= seq_error_d;
            mode_valid_q <= mode_valid_d;
            mode_q       <= state_d;
        end
    end

    assign bus.mode       = mode_q;
    assign bus.mode_valid = mode_valid_q;
    assign bus.seq_error  = seq_error_q;
    assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_signal_pattern_decoder.sv
// Self-checking bench for signal_pattern_decoder: directed scenarios plus a
// randomized stream, all compared against a sequence-table reference model.
module tb_signal_pattern_decoder;

    localparam int unsigned CW     = 4;
    localparam int          CycMax = (1 << CW) - 1;

    logic clk;
    logic rst;

    signal_pattern_decoder_if #(.CW(CW)) bus ();

    signal_pattern_decoder #(.CW(CW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; pos indexes the
    // mode's pattern table; mcnt saturates at 3; cyc saturates at CycMax.
    int md_state = 0;
    int md_pos   = 0;
    int md_m     = 0;
    int md_cyc   = 0;
    bit md_err   = 0;

    // Pattern tables as {L, R}.
    function automatic logic [5:0] seq_at(input int md, input int idx);
        logic [5:0] v;
        v = 6'b000_000;
        if (md == 1) begin
            case (idx)
                0: v = 6'b000_000;
                1: v = 6'b100_000;
                2: v = 6'b110_000;
                default: v = 6'b111_000;
            endcase
        end else if (md == 2) begin
            case (idx)
                0: v = 6'b000_000;
                1: v = 6'b000_001;
                2: v = 6'b000_011;
                default: v = 6'b000_111;
            endcase
        end else if (md == 3) begin
            v = (idx == 0) ? 6'b111_111 : 6'b000_000;
        end
        return v;
    endfunction

    function automatic int seq_len(input int md);
        return (md == 3) ? 2 : 4;
    endfunction

    task automatic model_idle();
        md_state = 0;
        md_pos   = 0;
        md_m     = 0;
        md_cyc   = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input logic [9:0] ledr);
        logic [5:0] lr;
        int nxt;
        lr = {ledr[9:7], ledr[2:0]};
        md_err = 0;
        if (r) begin
            model_idle();
            return;
        end
        if (!t) return;
        if (md_state == 0) begin
            if (lr == 6'b000_001) begin md_state = 2; md_pos = 1; md_m = 0; end
            else if (lr == 6'b100_000) begin md_state = 1; md_pos = 1; md_m = 0; end
            else if (lr == 6'b111_111) begin md_state = 3; md_pos = 0; md_m = 0; end
            else if (lr != 6'b000_000) md_err = 1;
        end else begin
            nxt = (md_pos + 1) % seq_len(md_state);
            if (lr == seq_at(md_state, nxt)) begin
                md_pos = nxt;
                if (md_m < 3) md_m++;
                if (lr == 6'b000_000 && md_cyc < CycMax) md_cyc++;
            end else begin
                if (lr != 6'b000_000) md_err = 1;
                model_idle();
            end
        end
    endtask

    function automatic logic [1:0] e_mode();
        return md_state[1:0];
    endfunction

    function automatic logic e_valid();
        return (md_state != 0) && (md_m >= 2);
    endfunction

    function automatic logic [CW-1:0] e_cyc();
        return md_cyc[CW-1:0];
    endfunction

    // Lamp word with random noise in the ignored middle bits.
    function automatic logic [9:0] mk(input logic [2:0] l, input logic [2:0] r);
        logic [3:0] mid;
        mid = 4'($urandom);
        return {l, mid, r};
    endfunction

    // Drive one edge's inputs away from the clock, update the model, sample after.
    task automatic step(input bit t, input logic [9:0] ledr);
        bit r_now;
        @(negedge clk);
        bus.tick = t;
        bus.LEDR = ledr;
        r_now    = rst;
        @(posedge clk);
        model_step(r_now, t, ledr);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 10'd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, mk(3'b111, 3'b111));
        rst = 1'b0;
        n_total++;
        if ({bus.mode, bus.mode_valid, bus.seq_error, bus.cycles} !== '0) begin
            $display("FAIL reset_outputs: got mode=%0d valid=%0d err=%0d cyc=%0d, required all 0",
                     bus.mode, bus.mode_valid, bus.seq_error, bus.cycles);
        end else n_pass++;
    endtask

    task automatic test_right_blink();
        logic [2:0] rs [5];
        bit err_seen;
        rs = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        err_seen = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk(3'b000, rs[i]));
            if (bus.seq_error !== 1'b0) err_seen = 1;
            n_total++;
            if (bus.mode !== e_mode() || bus.mode_valid !== e_valid() || bus.cycles !== e_cyc())
                $display("FAIL right_step%0d: got mode=%0d valid=%0d cyc=%0d, required %0d %0d %0d",
                         i, bus.mode, bus.mode_valid, bus.cycles, e_mode(), e_valid(), e_cyc());
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (bus.mode_valid !== 1'b1)
                    $display("FAIL right_valid_third: got %0d, required 1", bus.mode_valid);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++;
                if (bus.cycles !== 4'd1)
                    $display("FAIL right_cycles_fourth: got %0d, required 1", bus.cycles);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.mode !== 2'b10 || err_seen)
            $display("FAIL right_final: got mode=%0d err_seen=%0d, required mode=2 err_seen=0",
                     bus.mode, err_seen);
        else n_pass++;
    endtask

    task automatic test_hazard();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i % 2 == 0) ? mk(3'b111, 3'b111) : mk(3'b000, 3'b000));
            n_total++;
            if (bus.mode !== e_mode() || bus.mode_valid !== e_valid() || bus.cycles !== e_cyc()
                || bus.seq_error !== md_err)
                $display("FAIL hazard_step%0d: got mode=%0d valid=%0d cyc=%0d err=%0d, required %0d %0d %0d %0d",
                         i, bus.mode, bus.mode_valid, bus.cycles, bus.seq_error,
                         e_mode(), e_valid(), e_cyc(), md_err);
            else n_pass++;
        end
        n_total++;
        if (bus.mode !== 2'b11 || bus.cycles !== 4'd2 || bus.mode_valid !== 1'b1)
            $display("FAIL hazard_final: got mode=%0d cyc=%0d valid=%0d, required 3 2 1",
                     bus.mode, bus.cycles, bus.mode_valid);
        else n_pass++;
    endtask

    task automatic test_error();
        do_reset();
        step(1'b1, mk(3'b100, 3'b000));
        step(1'b1, mk(3'b110, 3'b000));
        step(1'b1, mk(3'b011, 3'b000));
        n_total++;
        if (bus.seq_error !== 1'b1 || bus.mode !== 2'b00 || bus.cycles !== 4'd0)
            $display("FAIL error_pulse: got err=%0d mode=%0d cyc=%0d, required 1 0 0",
                     bus.seq_error, bus.mode, bus.cycles);
        else n_pass++;
        step(1'b0, mk(3'b011, 3'b000));
        n_total++;
        if (bus.seq_error !== 1'b0)
            $display("FAIL error_one_clock: got err=%0d, required 0", bus.seq_error);
        else n_pass++;
        step(1'b1, mk(3'b100, 3'b000));
        n_total++;
        if (bus.mode !== 2'b01 || bus.seq_error !== 1'b0 || bus.mode !== e_mode())
            $display("FAIL error_reenter_left: got mode=%0d err=%0d, required mode=1 err=0",
                     bus.mode, bus.seq_error);
        else n_pass++;
    endtask

    task automatic test_cancel();
        do_reset();
        step(1'b1, mk(3'b000, 3'b001));
        step(1'b1, mk(3'b000, 3'b000));
        n_total++;
        if (bus.mode !== 2'b00 || bus.seq_error !== 1'b0)
            $display("FAIL cancel_dark: got mode=%0d err=%0d, required 0 0", bus.mode, bus.seq_error);
        else n_pass++;
        step(1'b1, mk(3'b010, 3'b000));
        n_total++;
        if (bus.seq_error !== 1'b1 || bus.mode !== 2'b00)
            $display("FAIL cancel_idle_illegal: got err=%0d mode=%0d, required 1 0",
                     bus.seq_error, bus.mode);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [2:0] rs [4];
        int bad;
        rs  = '{3'b011, 3'b111, 3'b000, 3'b001};
        bad = 0;
        do_reset();
        step(1'b1, mk(3'b000, 3'b001));
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, mk(3'b000, rs[k]));
                n_total++;
                if (bus.cycles !== e_cyc() || bus.mode_valid !== e_valid() || bus.mode !== e_mode()) begin
                    if (bad < 4)
                        $display("FAIL sat_c%0d_k%0d: got cyc=%0d valid=%0d mode=%0d, required %0d %0d %0d",
                                 c, k, bus.cycles, bus.mode_valid, bus.mode, e_cyc(), e_valid(), e_mode());
                    bad++;
                end else n_pass++;
            end
        end
        n_total++;
        if (bus.cycles !== 4'd15 || bus.mode_valid !== 1'b1)
            $display("FAIL sat_final: got cyc=%0d valid=%0d, required 15 1", bus.cycles, bus.mode_valid);
        else n_pass++;
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        step(1'b1, mk(3'b111, 3'b111));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'($urandom));
            n_total++;
            if (bus.mode !== 2'b11 || bus.cycles !== 4'd0 || bus.seq_error !== 1'b0)
                $display("FAIL hold_no_tick%0d: got mode=%0d cyc=%0d err=%0d, required 3 0 0",
                         i, bus.mode, bus.cycles, bus.seq_error);
            else n_pass++;
        end
        rst = 1'b1;
        step(1'b1, mk(3'b000, 3'b000));
        rst = 1'b0;
        n_total++;
        if ({bus.mode, bus.mode_valid, bus.seq_error, bus.cycles} !== '0)
            $display("FAIL reset_mid_hazard: got mode=%0d valid=%0d err=%0d cyc=%0d, required all 0",
                     bus.mode, bus.mode_valid, bus.seq_error, bus.cycles);
        else n_pass++;
        step(1'b1, mk(3'b100, 3'b000));
        n_total++;
        if (bus.mode !== 2'b01)
            $display("FAIL reset_then_left: got mode=%0d, required 1", bus.mode);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] lr;
        int sel;
        int bad;
        bit t;
        bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (md_state == 0) begin
                case ($urandom_range(0, 2))
                    0: lr = 6'b000_001;
                    1: lr = 6'b100_000;
                    default: lr = 6'b111_111;
                endcase
            end else begin
                lr = seq_at(md_state, (md_pos + 1) % seq_len(md_state));
            end
            if (sel >= 75 && sel < 85) lr = 6'b000_000;
            else if (sel >= 85) lr = 6'($urandom);
            t   = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 49) == 0);
            step(t, mk(lr[5:3], lr[2:0]));
            rst = 1'b0;
            n_total++;
            if (bus.mode !== e_mode() || bus.mode_valid !== e_valid() || bus.cycles !== e_cyc()
                || bus.seq_error !== md_err) begin
                if (bad < 5)
                    $display("FAIL random_%0d: got mode=%0d valid=%0d cyc=%0d err=%0d, required %0d %0d %0d %0d",
                             i, bus.mode, bus.mode_valid, bus.cycles, bus.seq_error,
                             e_mode(), e_valid(), e_cyc(), md_err);
                bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.tick = 1'b0;
        bus.LEDR = 10'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_right_blink();
        test_hazard();
        test_error();
        test_cancel();
        test_saturation();
        test_hold_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
